// File: rtl/mem_seq_arbiter.sv
// mem_seq_arbiter: round-robin N-master front end onto one synchronous-read memory port,
// with per-region wait states, byte-lane write enables and GBA-style read formatting.
module mem_seq_arbiter #(
   parameter int N_MST    = 2,
   parameter int WS_ROM   = 0,
   parameter int WS_INT   = 0,
   parameter int WS_IO    = 0,
   parameter int WS_VID   = 0,
   parameter int WS_PAK   = 2,
   parameter int WS_MAX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MST-1:0]     req,
   input  logic [N_MST-1:0]     we,
   input  logic [2*N_MST-1:0]   width,
   input  logic [32*N_MST-1:0]  addr,
   input  logic [32*N_MST-1:0]  wdata,
   output logic [N_MST-1:0]     ack,
   output logic [31:0]          rdata,
   output logic                 m_en,
   output logic                 m_we,
   output logic [3:0]           m_sel,
   output logic [23:0]          m_addr,
   output logic [3:0]           m_be,
   output logic [31:0]          m_wdata,
   input  logic [31:0]          m_rdata
);
   localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

   logic [1:0]          r_state;
   logic [PW-1:0]       r_ptr, r_gnt, w_gnt, w_ptr_nxt;
   logic                r_we, r_en, r_mwe;
   logic [1:0]          r_width, r_a;
   logic [3:0]          r_sel, r_be;
   logic [23:0]         r_addr;
   logic [31:0]         r_wdata, r_rdata;
   logic [N_MST-1:0]    r_ack;
   logic [WS_MAX_W-1:0] r_cnt, w_ws;
   logic [31:0]         w_addr_a [N_MST];
   logic [31:0]         w_wd_a [N_MST];
   logic [1:0]          w_width_a [N_MST];
   logic [31:0]         w_addr, w_wd, w_mwd, w_half, w_rfmt;
   logic [63:0]         w_dbl;
   logic [1:0]          w_width;
   logic [3:0]          w_be;
   logic                w_we, w_map, w_unused;

   function automatic logic mapped(input logic [3:0] s);
      return !(s == 4'h1 || s >= 4'hE);
   endfunction

   function automatic logic [WS_MAX_W-1:0] ws_of(input logic [3:0] s);
      return (s == 4'h0) ? WS_MAX_W'(WS_ROM) :
             (s == 4'h2 || s == 4'h3) ? WS_MAX_W'(WS_INT) :
             (s == 4'h4) ? WS_MAX_W'(WS_IO) :
             (s >= 4'h5 && s <= 4'h7) ? WS_MAX_W'(WS_VID) :
             (s >= 4'h8 && s <= 4'hD) ? WS_MAX_W'(WS_PAK) : '0;
   endfunction

   for (genvar g = 0; g < N_MST; g++) begin : g_unpack
      assign w_addr_a[g]  = addr[32*g +: 32];
      assign w_wd_a[g]    = wdata[32*g +: 32];
      assign w_width_a[g] = width[2*g +: 2];
   end

   // Descending scan so the requester closest at/after the pointer wins.
   always_comb begin
      logic [PW-1:0] j;
      j     = '0;
      w_gnt = '0;
      for (int i = N_MST - 1; i >= 0; i--) begin
         j = PW'((int'(r_ptr) + i) % N_MST);
         if (req[j]) w_gnt = j;
      end
   end

   assign w_ptr_nxt = PW'((int'(w_gnt) + 1) % N_MST);
   assign w_addr    = w_addr_a[w_gnt];
   assign w_wd      = w_wd_a[w_gnt];
   assign w_width   = w_width_a[w_gnt];
   assign w_we      = we[w_gnt];
   assign w_map     = mapped(w_addr[27:24]);
   assign w_unused  = ^w_addr[31:28];
   assign w_be      = (w_width == 2'd0) ? 4'b0001 << w_addr[1:0] :
                      (w_width == 2'd1) ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign w_mwd     = (w_width == 2'd0) ? {4{w_wd[7:0]}} :
                      (w_width == 2'd1) ? {2{w_wd[15:0]}} : w_wd;
   assign w_ws      = ws_of(r_sel);

   // Doubling the word turns the rotate into a plain shift.
   assign w_dbl  = {m_rdata, m_rdata} >> {r_a, 3'b000};
   assign w_half = r_a[1] ? {16'h0, m_rdata[31:16]} : {16'h0, m_rdata[15:0]};
   assign w_rfmt = !mapped(r_sel) ? 32'h0 :
                   (r_width == 2'd0) ? {24'h0, w_dbl[7:0]} :
                   (r_width == 2'd1) ? (r_a[0] ? {w_half[7:0], w_half[31:8]} : w_half) :
                   w_dbl[31:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_we    <= 1'b0;
         r_width <= '0;
         r_a     <= '0;
         r_sel   <= '0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_en    <= 1'b0;
         r_mwe   <= 1'b0;
         r_cnt   <= '0;
         r_ack   <= '0;
         r_rdata <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: if (|req) begin
               r_gnt   <= w_gnt;
               r_ptr   <= w_ptr_nxt;
               r_we    <= w_we;
               r_width <= w_width;
               r_a     <= w_addr[1:0];
               r_sel   <= w_addr[27:24];
               r_addr  <= {w_addr[23:2], 2'b00};
               r_be    <= w_be;
               r_wdata <= w_mwd;
               r_en    <= w_map;
               r_mwe   <= w_we && w_map && (w_addr[27:24] != 4'h0);
               r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               r_en    <= 1'b0;
               r_mwe   <= 1'b0;
               r_cnt   <= w_ws;
               r_state <= (w_ws != '0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
               r_cnt   <= r_cnt - WS_MAX_W'(1);
               r_state <= (r_cnt <= WS_MAX_W'(1)) ? S_DONE : S_WAIT;
            end
            default: begin
               r_ack   <= N_MST'(1) << r_gnt;
               r_rdata <= r_we ? r_rdata : w_rfmt;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ack     = r_ack;
   assign rdata   = r_rdata;
   assign m_en    = r_en;
   assign m_we    = r_mwe;
   assign m_sel   = r_sel;
   assign m_addr  = r_addr;
   assign m_be    = r_be;
   assign m_wdata = r_wdata;
endmodule

// File: tb/tb_mem_seq_arbiter.sv
// tb_mem_seq_arbiter: directed stimulus with a transaction-level timing model
// checked every cycle, plus literal expectations for key accesses.
module tb_mem_seq_arbiter;
   localparam int N = 2;

   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  req = '0, we = '0;
   logic [3:0]  width = '0;
   logic [63:0] addr = '0, wdata = '0;
   logic [1:0]  ack;
   logic [31:0] rdata, m_wdata, m_rdata = '0, rd_val = '0;
   logic        m_en, m_we;
   logic [3:0]  m_sel, m_be;
   logic [23:0] m_addr;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem_seq_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .width(width), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .m_en(m_en), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
      .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // Memory with a 1-cycle synchronous read that holds its output between accesses.
   always @(posedge clk) if (m_en && !m_we) m_rdata <= rd_val;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int ws_of(input logic [3:0] r);
      return (r >= 4'h8 && r <= 4'hD) ? 2 : 0;
   endfunction

   function automatic bit map_of(input logic [3:0] r);
      return !(r == 4'h1 || r >= 4'hE);
   endfunction

   function automatic logic [31:0] fmt(input logic [31:0] v, input logic [1:0] w, input logic [1:0] a);
      logic [31:0] h;
      if (w == 2'd0) return (v >> (8 * a)) & 32'hFF;
      if (w == 2'd1) begin
         h = (v >> (16 * a[1])) & 32'hFFFF;
         return a[0] ? ((h >> 8) | (h << 24)) : h;
      end
      return (v >> (8 * a)) | (v << (32 - 8 * a));
   endfunction

   function automatic logic [3:0] be_of(input logic [1:0] w, input logic [1:0] a);
      if (w == 2'd0) return 4'(1 << a);
      if (w == 2'd1) return (a >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] wd_of(input logic [1:0] w, input logic [31:0] d);
      if (w == 2'd0) return {4{d[7:0]}};
      if (w == 2'd1) return {2{d[15:0]}};
      return d;
   endfunction

   int          cyc = 0, free_at = 0, t_grant = -10, t_ack = -10, ptr = 0, g = 0, mj;
   bit          act = 0, g_we, g_map, mf, x_en, x_we, x_hold;
   logic [3:0]  g_sel;
   logic [1:0]  g_w, g_a, x_ack;
   logic [31:0] g_addr, g_wd, g_rv, e_rdata = '0;

   // Model: a grant happens at any edge where the port is free and someone requests;
   // the transaction then occupies 3+WS edges, ack landing on the edge before it frees.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         ptr = 0; act = 0; free_at = cyc + 1; e_rdata = '0;
      end else begin
         if (act && cyc == t_ack && !g_we) e_rdata = g_map ? fmt(g_rv, g_w, g_a) : 32'h0;
         if (cyc >= free_at && req != 0) begin
            mf = 0;
            for (int i = 0; i < N; i++) begin
               mj = (ptr + i) % N;
               if (!mf && req[mj]) begin g = mj; mf = 1; end
            end
            g_we = we[g]; g_w = width[2*g +: 2]; g_addr = addr[32*g +: 32]; g_wd = wdata[32*g +: 32];
            g_sel = g_addr[27:24]; g_a = g_addr[1:0]; g_map = map_of(g_sel); g_rv = rd_val;
            t_grant = cyc; t_ack = cyc + 2 + ws_of(g_sel); free_at = t_ack + 1;
            ptr = (g + 1) % N; act = 1;
         end
      end
      x_ack  = (!rst && act && cyc == t_ack) ? 2'(1 << g) : 2'b00;
      x_en   = !rst && act && cyc == t_grant && g_map;
      x_we   = x_en && g_we && g_sel != 4'h0;
      x_hold = !rst && act && cyc >= t_grant && cyc < t_ack;
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ack", ack, 0); chk("rst_rdata", rdata, 0); chk("rst_m_en", m_en, 0);
         chk("rst_m_we", m_we, 0); chk("rst_m_be", m_be, 0); chk("rst_m_sel", m_sel, 0);
         chk("rst_m_addr", m_addr, 0); chk("rst_m_wdata", m_wdata, 0);
      end else begin
         chk("ack", ack, x_ack); chk("m_en", m_en, x_en); chk("m_we", m_we, x_we);
         chk("rdata", rdata, e_rdata);
         if (x_hold) begin
            chk("m_sel", m_sel, g_sel); chk("m_addr", m_addr, {g_addr[23:2], 2'b00});
            chk("m_be", m_be, be_of(g_w, g_a)); chk("m_wdata", m_wdata, wd_of(g_w, g_wd));
         end
      end
   end

   int          lat;
   logic [31:0] s_be, s_wd;
   bit          s_en, s_we;

   task automatic txn(input int m, input bit w_e, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d);
      @(negedge clk); #1;
      we[m] = w_e; width[2*m +: 2] = w; addr[32*m +: 32] = a; wdata[32*m +: 32] = d; req[m] = 1'b1;
      lat = 0; s_en = 0; s_we = 0; s_be = '0; s_wd = '0;
      while (!ack[m] && lat < 30) begin
         @(negedge clk); #1;
         lat++;
         if (lat == 1) begin s_en = m_en; s_we = m_we; s_be = 32'(m_be); s_wd = m_wdata; end
      end
      req[m] = 1'b0;
      checks++;
      if (!ack[m]) begin errors++; $display("FAIL timeout master %0d got no ack want ack", m); end
      lat = lat - 1;
   endtask

   logic [1:0] seq [4];
   int         tm [4];
   int         n, c;

   initial begin
      req = 2'b11; width = 4'b1010; addr = {32'h0200_0004, 32'h0200_0000}; rd_val = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin seq[i] = '0; tm[i] = 0; end
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         if (ack != 0 && n < 4) begin seq[n] = ack; tm[n] = k; n++; end
      end
      req = '0;
      chk("rr_count", n, 4);
      chk("rr_first_lat", tm[0], 2);
      for (int i = 0; i < 4; i++) chk("rr_order", seq[i], (i % 2) ? 2'b10 : 2'b01);
      for (int i = 1; i < 4; i++) chk("rr_period", tm[i] - tm[i-1], 3);

      txn(0, 1, 2'd0, 32'h0300_0002, 32'h0000_00A5);
      chk("bw_lat", lat, 2); chk("bw_be", s_be, 4'b0100); chk("bw_wd", s_wd, 32'hA5A5_A5A5);
      chk("bw_we", s_we, 1); chk("bw_en", s_en, 1);

      rd_val = 32'h1122_3344;
      txn(1, 0, 2'd2, 32'h0800_0001, 32'h0);
      chk("pak_lat", lat, 4); chk("pak_rdata", rdata, 32'h4411_2233);

      rd_val = 32'hAABB_CCDD;
      txn(0, 0, 2'd1, 32'h0200_0003, 32'h0);
      chk("h3_rdata", rdata, 32'hBB00_00AA);
      txn(0, 0, 2'd1, 32'h0200_0002, 32'h0);
      chk("h2_rdata", rdata, 32'h0000_AABB);
      txn(1, 0, 2'd0, 32'h0400_0001, 32'h0);
      chk("b1_rdata", rdata, 32'h0000_00CC);
      txn(1, 1, 2'd1, 32'h0600_0002, 32'h0000_1234);
      chk("hw_be", s_be, 4'b1100); chk("hw_wd", s_wd, 32'h1234_1234); chk("hw_keep", rdata, 32'h0000_00CC);

      txn(0, 1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
      chk("rom_we", s_we, 0); chk("rom_en", s_en, 1); chk("rom_lat", lat, 2);
      rd_val = 32'hFFFF_FFFF;
      txn(0, 0, 2'd2, 32'h0E00_0000, 32'h0);
      chk("um_en", s_en, 0); chk("um_rdata", rdata, 32'h0); chk("um_lat", lat, 2);

      @(negedge clk); #1;
      rd_val = 32'h0000_0055; we[0] = 1'b0; width[1:0] = 2'd2; addr[31:0] = 32'h0800_0000; req[0] = 1'b1;
      repeat (2) begin @(negedge clk); #1; end
      rst = 1'b1; req = '0;
      #1 chk("ar_m_en", m_en, 0); chk("ar_ack", ack, 0);
      @(negedge clk); #1;
      chk("ar_ack2", ack, 0);
      rst = 1'b0;
      we = 2'b00; width = 4'b1010; addr = {32'h0200_0004, 32'h0200_0000}; rd_val = 32'h0BAD_F00D;
      req = 2'b11;
      c = 0;
      while (ack == 0 && c < 20) begin @(negedge clk); #1; c++; end
      req = '0;
      chk("ar_first", ack, 2'b01); chk("ar_lat", c - 1, 2); chk("ar_rdata", rdata, 32'h0BAD_F00D);
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
